// File: rtl/seg7_capture.sv
// Reader for a multiplexed active-low 7-segment bus: waits for each scanned digit to settle,
// decodes it back to a nibble and flags blank/illegal glyphs, pulsing once per complete frame.

module seg7_capture_digit (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       cap,
    input  logic       is_glyph,
    input  logic       is_blank,
    input  logic [3:0] nib,
    output logic [3:0] value,
    output logic       valid,
    output logic       blank,
    output logic       err
);
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= 4'h0;
            valid <= 1'b0;
            blank <= 1'b0;
            err   <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
            blank <= 1'b0;
            err   <= 1'b0;
        end else if (cap) begin
            valid <= is_glyph;
            blank <= is_blank;
            err   <= !is_glyph && !is_blank;
            // Blank and illegal captures keep the last good nibble.
            if (is_glyph) value <= nib;
        end
    end
endmodule

module seg7_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_n,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid
);
    localparam int          PW      = 7 + NUM_DIGITS;
    localparam logic [7:0]  CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0]  CNT_CAP = 8'(STABLE_CYCLES - 1);

    logic [PW-1:0]         s_in, s_reg, s_prev;
    logic [7:0]            cnt;
    logic [NUM_DIGITS-1:0] seen, sel, cap;
    logic                  same, one_cold, strobe, take;
    logic                  is_glyph, is_blank;
    logic [3:0]            nib;
    logic [6:0]            seg_s;

    assign s_in = {seg_n, dig_n};

    // Compare the pair about to be registered against the one already held, so cnt
    // counts how long s_reg has been stable after this edge; the capture then lands
    // on the (STABLE_CYCLES+1)th edge after the pair reaches the ports.
    assign same     = (s_in == s_reg);
    assign sel      = ~s_prev[NUM_DIGITS-1:0];
    assign one_cold = ($countones(sel) == 1);
    assign strobe   = same && (cnt == CNT_CAP) && one_cold;
    assign take     = strobe && !clear;
    assign cap      = take ? sel : '0;
    assign seg_s    = s_prev[PW-1:NUM_DIGITS];

    always_ff @(posedge clk) begin
        if (reset) begin
            s_reg  <= '0;
            s_prev <= '0;
            cnt    <= 8'd0;
        end else begin
            s_reg  <= s_in;
            s_prev <= s_reg;
            if (!same)               cnt <= 8'd0;
            else if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
        end
    end

    always_comb begin
        is_glyph = 1'b1;
        nib      = 4'h0;
        case (seg_s)
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: is_glyph = 1'b0;
        endcase
    end

    assign is_blank = (seg_s == 7'h7F);

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        seg7_capture_digit u_dig (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear),
            .cap      (cap[k]),
            .is_glyph (is_glyph),
            .is_blank (is_blank),
            .nib      (nib),
            .value    (value[4*k +: 4]),
            .valid    (digit_valid[k]),
            .blank    (digit_blank[k]),
            .err      (digit_err[k])
        );
    end

    // The completing capture starts a fresh frame rather than being kept in seen.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            seen        <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (take) begin
                if ((seen | sel) == {NUM_DIGITS{1'b1}}) begin
                    frame_valid <= 1'b1;
                    seen        <= '0;
                end else begin
                    seen <= seen | sel;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: settle timing, decode, blank/err, frame pulses, clear and reset.

module tb_seg7_capture;
    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  seg_n;
    logic [3:0]  dig_n;
    logic        clear;
    logic [15:0] value;
    logic [3:0]  digit_valid, digit_blank, digit_err;
    logic        frame_valid;

    int checks = 0;
    int errors = 0;
    int fv_cnt, fv_edge, fv_tot;

    seg7_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_n       (seg_n),
        .dig_n       (dig_n),
        .clear       (clear),
        .value       (value),
        .digit_valid (digit_valid),
        .digit_blank (digit_blank),
        .digit_err   (digit_err),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present a pair and hold it for n edges; inputs change just after an edge,
    // so the first edge inside the loop is edge 1 of the hold.
    task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
        seg_n   = s;
        dig_n   = d;
        fv_cnt  = 0;
        fv_edge = 0;
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            #1;
            if (frame_valid) begin
                fv_cnt++;
                fv_edge = e;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [6:0] pat [4] = '{7'h79, 7'h24, 7'h30, 7'h19};

    initial begin
        seg_n = 7'h7F;
        dig_n = 4'hF;
        clear = 1'b0;
        do_reset();
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_valid", 32'(digit_valid), 32'h0);
        chk("rst_blank", 32'(digit_blank), 32'h0);
        chk("rst_err",   32'(digit_err), 32'h0);
        chk("rst_fv",    32'(frame_valid), 32'h0);

        // 1: single held digit, capture on edge 9 and only once
        hold(7'h40, 4'b1110, 8);
        chk("t1_valid_e8", 32'(digit_valid), 32'h0);
        hold(7'h40, 4'b1110, 1);
        chk("t1_valid_e9", 32'(digit_valid), 32'h1);
        chk("t1_value", 32'(value[3:0]), 32'h0);
        hold(7'h40, 4'b1110, 11);
        clear = 1'b1;
        hold(7'h40, 4'b1110, 1);
        clear = 1'b0;
        chk("t1_clear", 32'(digit_valid), 32'h0);
        hold(7'h40, 4'b1110, 10);
        chk("t1_norecap", 32'(digit_valid), 32'h0);

        // 2: two full scans, one frame pulse each on the digit-3 capture edge
        for (int pass = 0; pass < 2; pass++) begin
            fv_tot = 0;
            for (int k = 0; k < 4; k++) begin
                hold(pat[k], ~(4'b0001 << k), 12);
                fv_tot += fv_cnt;
            end
            chk("t2_fv_count", 32'(fv_tot), 32'd1);
            chk("t2_fv_edge", 32'(fv_edge), 32'd9);
            chk("t2_value", 32'(value), 32'h4321);
            chk("t2_valid", 32'(digit_valid), 32'hF);
        end

        // 3: segment lines toggling faster than the settle window
        do_reset();
        for (int i = 0; i < 6; i++) hold((i % 2) ? 7'h79 : 7'h40, 4'b1110, 5);
        chk("t3_value", 32'(value), 32'h0);
        chk("t3_valid", 32'(digit_valid), 32'h0);
        chk("t3_err",   32'(digit_err), 32'h0);

        // 4: glyph, then blank, then illegal on digit 2
        hold(7'h24, 4'b1011, 12);
        chk("t4_glyph", 32'(digit_valid), 32'h4);
        hold(7'h7F, 4'b1011, 12);
        chk("t4_blank", 32'(digit_blank), 32'h4);
        chk("t4_blank_valid", 32'(digit_valid), 32'h0);
        chk("t4_blank_value", 32'(value[11:8]), 32'h2);
        hold(7'h55, 4'b1011, 12);
        chk("t4_err", 32'(digit_err), 32'h4);
        chk("t4_err_blank", 32'(digit_blank), 32'h0);
        chk("t4_err_value", 32'(value[11:8]), 32'h2);

        // 5: illegal digit selects never capture
        hold(7'h00, 4'b1100, 20);
        hold(7'h00, 4'b1111, 20);
        chk("t5_nocap_valid", 32'(digit_valid), 32'h0);
        chk("t5_nocap_err", 32'(digit_err), 32'h4);
        chk("t5_nocap_value", 32'(value), 32'h0200);
        hold(7'h00, 4'b0111, 12);
        chk("t5_value", 32'(value[15:12]), 32'h8);
        chk("t5_valid", 32'(digit_valid), 32'h8);
        chk("t5_no_fv", 32'(fv_cnt), 32'd0);

        // 6: clear coinciding with a capture discards it and empties seen
        hold(7'h30, 4'b1101, 12);
        chk("t6_pre_value", 32'(value[7:4]), 32'h3);
        hold(7'h19, 4'b1101, 8);
        clear = 1'b1;
        hold(7'h19, 4'b1101, 1);
        clear = 1'b0;
        chk("t6_valid", 32'(digit_valid), 32'h0);
        chk("t6_blank", 32'(digit_blank), 32'h0);
        chk("t6_err",   32'(digit_err), 32'h0);
        chk("t6_value", 32'(value[7:4]), 32'h3);
        chk("t6_fv",    32'(fv_cnt), 32'd0);
        hold(7'h19, 4'b1101, 10);
        chk("t6_norecap", 32'(digit_valid), 32'h0);
        hold(7'h40, 4'b1110, 12);
        chk("t6_seen_cleared", 32'(fv_cnt), 32'd0);

        // reset mid-frame, then scan out of order: pulse only when all four are seen
        hold(7'h79, 4'b1101, 12);
        do_reset();
        fv_tot = 0;
        hold(7'h24, 4'b1011, 12); fv_tot += fv_cnt;
        hold(7'h30, 4'b0111, 12); fv_tot += fv_cnt;
        chk("t6_rst_no_fv", 32'(fv_tot), 32'd0);
        hold(7'h40, 4'b1110, 12);
        chk("t6_rst_no_fv3", 32'(fv_cnt), 32'd0);
        hold(7'h79, 4'b1101, 12);
        chk("t6_rst_fv", 32'(fv_cnt), 32'd1);
        chk("t6_rst_fv_edge", 32'(fv_edge), 32'd9);
        chk("t6_rst_value", 32'(value), 32'h3210);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
